// File: rtl/soc_bus_arb.sv
// Two-master, round-robin bus arbiter with registered slave handshake,
// address decode into NUM_SLAVES one-hot selects, slave-ack timeout and decode-error response.
module soc_bus_arb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_BITS       = 4,
  parameter int NUM_SLAVES     = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             m0_req_i,
  input  logic                             m1_req_i,
  input  logic [ADDR_WIDTH-1:0]            m0_addr_i,
  input  logic [ADDR_WIDTH-1:0]            m1_addr_i,
  input  logic [DATA_WIDTH-1:0]            m0_wdata_i,
  input  logic [DATA_WIDTH-1:0]            m1_wdata_i,
  input  logic                             m0_we_i,
  input  logic                             m1_we_i,
  input  logic                             m0_rd_i,
  input  logic                             m1_rd_i,
  output logic [DATA_WIDTH-1:0]            m0_rdata_o,
  output logic [DATA_WIDTH-1:0]            m1_rdata_o,
  output logic                             m0_ack_o,
  output logic                             m1_ack_o,
  output logic                             m0_err_o,
  output logic                             m1_err_o,
  output logic [NUM_SLAVES-1:0]            s_req_o,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  output logic                             s_we_o,
  output logic                             s_rd_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]            s_ack_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;    // 1: m1 won the most recent tie
  logic                  gnt_q, gnt_d;      // 1: m1 owns the current transaction
  logic [SEL_BITS-1:0]   sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  grant_m1;
  logic                  ack_sel;
  logic [DATA_WIDTH-1:0] data_sel;

  // Only the latched slave's ack/data are visible; stray acks elsewhere are ignored.
  always_comb begin
    ack_sel  = 1'b0;
    data_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q == SEL_BITS'(k)) begin
        ack_sel  = s_ack_i[k];
        data_sel = s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // NOTE: every variable gets a default at the top of this block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    grant_m1 = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_req_i || m1_req_i) begin
          if (m0_req_i && m1_req_i) begin
            grant_m1 = ~last_q;
            last_d   = ~last_q;
          end else begin
            grant_m1 = m1_req_i;
          end
          gnt_d   = grant_m1;
          addr_d  = grant_m1 ? m1_addr_i  : m0_addr_i;
          wdata_d = grant_m1 ? m1_wdata_i : m0_wdata_i;
          we_d    = grant_m1 ? m1_we_i    : m0_we_i;
          rd_d    = grant_m1 ? m1_rd_i    : m0_rd_i;
          sel_d   = addr_d[ADDR_WIDTH-1 -: SEL_BITS];
          cnt_d   = '0;
          if (32'(sel_d) < NUM_SLAVES) begin
            state_d = ST_BUSY;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack in the timeout cycle still completes the transfer cleanly.
        if (ack_sel) begin
          rdata_d = we_q ? '0 : data_sel;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous
  // so outputs clear immediately even mid-transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    s_req_o = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      s_req_o[k] = (state_q == ST_BUSY) && (sel_q == SEL_BITS'(k));
    end
  end

  assign m0_ack_o   = (state_q == ST_RESP) && !gnt_q;
  assign m1_ack_o   = (state_q == ST_RESP) &&  gnt_q;
  assign m0_rdata_o = m0_ack_o ? rdata_q : '0;
  assign m1_rdata_o = m1_ack_o ? rdata_q : '0;
  assign m0_err_o   = m0_ack_o & err_q;
  assign m1_err_o   = m1_ack_o & err_q;
  assign s_addr_o   = addr_q;
  assign s_wdata_o  = wdata_q;
  assign s_we_o     = we_q;
  assign s_rd_o     = rd_q;

endmodule

// File: tb/tb_soc_bus_arb.sv
// Directed bench for soc_bus_arb: transaction-timeline reference model checked every
// cycle, plus literal latency/data expectations for each scenario.
module tb_soc_bus_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SB = 4;
  localparam int NS = 7;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_we, m1_we, m0_rd, m1_rd;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic [NS-1:0] s_req;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_we, s_rd;
  logic [NS*DW-1:0] s_data;
  logic [NS-1:0] s_ack;
  logic [NS-1:0] stray_ack;

  int            slv_lat [NS];
  logic [DW-1:0] slv_dat [NS];
  int            slv_cnt [NS];
  int            sreq_cycles [NS];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  soc_bus_arb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_BITS(SB), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m1_req_i(m1_req),
    .m0_addr_i(m0_addr), .m1_addr_i(m1_addr),
    .m0_wdata_i(m0_wdata), .m1_wdata_i(m1_wdata),
    .m0_we_i(m0_we), .m1_we_i(m1_we), .m0_rd_i(m0_rd), .m1_rd_i(m1_rd),
    .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
    .m0_ack_o(m0_ack), .m1_ack_o(m1_ack),
    .m0_err_o(m0_err), .m1_err_o(m1_err),
    .s_req_o(s_req), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_we_o(s_we), .s_rd_o(s_rd),
    .s_data_i(s_data), .s_ack_i(s_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Slave models: slave k acks after seeing its select for slv_lat[k] prior cycles.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < NS; k++) begin
      if (rst) slv_cnt[k] <= 0;
      else     slv_cnt[k] <= s_req[k] ? slv_cnt[k] + 1 : 0;
    end
  end

  always_comb begin
    s_ack  = '0;
    s_data = '0;
    for (int k = 0; k < NS; k++) begin
      s_ack[k] = (s_req[k] && (slv_cnt[k] == slv_lat[k])) || stray_ack[k];
      s_data[k*DW +: DW] = slv_dat[k];
    end
  end

  // Reference model: on each idle cycle with a request, predict the whole
  // transaction timeline (grant cycle, select window, response cycle and payload).
  int            free_at = 0;
  bit            last_tie = 1'b1;
  bit            t_valid = 1'b0;
  int            t_grant, t_busy, t_sel;
  bit            t_m, t_err;
  logic [DW-1:0] t_rdata;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          e_we, e_rd;

  always @(negedge clk) begin : cmp
    logic [NS-1:0] e_sreq;
    logic [AW-1:0] a;
    int            c;
    bit            g;
    c = cyc;
    if (rst) begin
      check("rst_s_req", s_req, 0);
      check("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
      check("rst_rdata", {m0_rdata, m1_rdata}, 0);
      check("rst_s_bus", {s_addr, s_wdata, s_we, s_rd}, 0);
      t_valid  = 1'b0;
      last_tie = 1'b1;
      free_at  = c;
      e_addr = '0; e_wdata = '0; e_we = 1'b0; e_rd = 1'b0;
    end else begin
      e_sreq = '0;
      if (t_valid && c > t_grant && c <= t_grant + t_busy) e_sreq = NS'(1) << t_sel;
      check("s_req", s_req, e_sreq);
      if (e_sreq != '0) begin
        check("s_addr", s_addr, e_addr);
        check("s_wdata", s_wdata, e_wdata);
        check("s_we", s_we, e_we);
        check("s_rd", s_rd, e_rd);
      end
      if (t_valid && c == t_grant + t_busy + 1) begin
        check("m0_ack", m0_ack, !t_m);
        check("m1_ack", m1_ack, t_m);
        check("m0_err", m0_err, !t_m && t_err);
        check("m1_err", m1_err, t_m && t_err);
        check("m0_rdata", m0_rdata, t_m ? '0 : t_rdata);
        check("m1_rdata", m1_rdata, t_m ? t_rdata : '0);
      end else begin
        check("m0_ack_idle", m0_ack, 0);
        check("m1_ack_idle", m1_ack, 0);
      end
      for (int k = 0; k < NS; k++) sreq_cycles[k] += int'(s_req[k]);

      if (c >= free_at && (m0_req || m1_req)) begin
        if (m0_req && m1_req) begin
          g = !last_tie;
          last_tie = g;
        end else begin
          g = m1_req;
        end
        a       = g ? m1_addr : m0_addr;
        e_addr  = a;
        e_wdata = g ? m1_wdata : m0_wdata;
        e_we    = g ? m1_we : m0_we;
        e_rd    = g ? m1_rd : m0_rd;
        t_m     = g;
        t_sel   = int'(a[AW-1 -: SB]);
        t_grant = c;
        t_valid = 1'b1;
        if (t_sel >= NS) begin
          t_busy = 0; t_err = 1'b1; t_rdata = '0;
        end else if (slv_lat[t_sel] < TO) begin
          t_busy = slv_lat[t_sel] + 1; t_err = 1'b0;
          t_rdata = e_we ? '0 : slv_dat[t_sel];
        end else begin
          t_busy = TO; t_err = 1'b1; t_rdata = '0;
        end
        free_at = c + t_busy + 2;
      end
    end
  end

  task automatic master_txn(input int m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic we, input logic rd, output int lat, output int ack_cyc,
                            output logic [DW-1:0] rdata, output logic err);
    int start;
    bit got;
    @(posedge clk); #1;
    if (m == 0) begin
      m0_req = 1'b1; m0_addr = a; m0_wdata = wd; m0_we = we; m0_rd = rd;
    end else begin
      m1_req = 1'b1; m1_addr = a; m1_wdata = wd; m1_we = we; m1_rd = rd;
    end
    start   = cyc;
    got     = 1'b0;
    ack_cyc = -1;
    rdata   = '0;
    err     = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) begin
        got     = 1'b1;
        ack_cyc = cyc;
        rdata   = (m == 0) ? m0_rdata : m1_rdata;
        err     = (m == 0) ? m0_err : m1_err;
      end
    end
    check("ack_within_budget", got, 1);
    lat = got ? ack_cyc - start : -1;
    @(posedge clk); #1;
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  int            lat0, lat1, ac0, ac1, base;
  logic [DW-1:0] rd0, rd1;
  logic          er0, er1;

  initial begin
    m0_req = 0; m1_req = 0; m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_we = 0; m1_we = 0; m0_rd = 0; m1_rd = 0; stray_ack = '0;
    slv_lat = '{0, 0, 1000, 1, 3, 0, 2};
    slv_dat = '{32'hA000_0000, 32'hDEAD_BEEF, 32'hA222_2222, 32'hA333_3333,
                32'hA444_4444, 32'hA555_5555, 32'hA666_6666};
    for (int k = 0; k < NS; k++) sreq_cycles[k] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_literal", {m0_ack, m1_ack, s_req, s_addr}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: m0 read, slave 1 combinational ack
    base = sreq_cycles[1];
    master_txn(0, 32'h1000_0040, '0, 1'b0, 1'b1, lat0, ac0, rd0, er0);
    check("t1_latency", lat0, 2);
    check("t1_rdata", rd0, 32'hDEAD_BEEF);
    check("t1_err", er0, 0);
    check("t1_sreq_cycles", sreq_cycles[1] - base, 1);

    // 2: simultaneous requests, twice: m0 then m1, then m1 then m0
    fork
      master_txn(0, 32'h0000_0000, '0, 1'b0, 1'b1, lat0, ac0, rd0, er0);
      master_txn(1, 32'h3000_0004, '0, 1'b0, 1'b1, lat1, ac1, rd1, er1);
    join
    check("t2a_order_gap", ac1 - ac0, 4);
    check("t2a_m0_rdata", rd0, 32'hA000_0000);
    check("t2a_m1_rdata", rd1, 32'hA333_3333);
    fork
      master_txn(0, 32'h0000_0000, '0, 1'b0, 1'b1, lat0, ac0, rd0, er0);
      master_txn(1, 32'h3000_0004, '0, 1'b0, 1'b1, lat1, ac1, rd1, er1);
    join
    check("t2b_order_gap", ac0 - ac1, 3);

    // 3: unmapped write from m1
    base = 0;
    for (int k = 0; k < NS; k++) base += sreq_cycles[k];
    master_txn(1, 32'h7000_0000, 32'h1234_5678, 1'b1, 1'b0, lat1, ac1, rd1, er1);
    check("t3_latency", lat1, 1);
    check("t3_err", er1, 1);
    check("t3_rdata", rd1, 0);
    for (int k = 0; k < NS; k++) base -= sreq_cycles[k];
    check("t3_no_slave_touched", base, 0);

    // 4: slave 2 never acks -> timeout after 4 busy cycles
    base = sreq_cycles[2];
    master_txn(0, 32'h2000_0000, '0, 1'b0, 1'b1, lat0, ac0, rd0, er0);
    check("t4_sreq_cycles", sreq_cycles[2] - base, 4);
    check("t4_latency", lat0, 5);
    check("t4_err", er0, 1);
    check("t4_rdata", rd0, 0);

    // 5: slave 4 acks in the same cycle the timeout would fire
    master_txn(1, 32'h4000_0010, '0, 1'b0, 1'b1, lat1, ac1, rd1, er1);
    check("t5_latency", lat1, 5);
    check("t5_err", er1, 0);
    check("t5_rdata", rd1, 32'hA444_4444);

    // write to a mapped slave returns zero read data
    master_txn(0, 32'h5000_0008, 32'hCAFE_F00D, 1'b1, 1'b0, lat0, ac0, rd0, er0);
    check("wr_latency", lat0, 2);
    check("wr_rdata", rd0, 0);
    check("wr_err", er0, 0);

    // stray ack on slave 0 while slave 6 is addressed
    stray_ack = 7'b0000001;
    master_txn(0, 32'h6000_0000, '0, 1'b0, 1'b1, lat0, ac0, rd0, er0);
    stray_ack = '0;
    check("stray_latency", lat0, 4);
    check("stray_rdata", rd0, 32'hA666_6666);

    // 6: reset during BUSY abandons the transaction
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 32'h2000_0000; m0_we = 1'b0; m0_rd = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    check("t6_in_reset", {m0_ack, m1_ack, m0_err, m1_err, s_req}, 0);
    @(posedge clk); #1 rst = 1'b0;
    master_txn(1, 32'h3000_0000, '0, 1'b0, 1'b1, lat1, ac1, rd1, er1);
    check("t6_m1_latency", lat1, 3);
    check("t6_m1_rdata", rd1, 32'hA333_3333);
    fork
      master_txn(0, 32'h0000_0004, '0, 1'b0, 1'b1, lat0, ac0, rd0, er0);
      master_txn(1, 32'h1000_0000, '0, 1'b0, 1'b1, lat1, ac1, rd1, er1);
    join
    check("t6_m0_wins_tie", ac1 - ac0, 3);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
